pwm_multi_dt: RTL and testbench

- Parametrised, multi-channel successor to the single-output PWM used for the open-loop converter drive and for sample-rate (Fs) generation.
- One shared carrier counter drives CH phase-shifted channels. Each channel produces a complementary high/low pair with programmable dead time.
- A programmable ADC trigger pulse is locked to the carrier, replacing the separate Fs PWM.
- Glitch-free double-buffered updates feed the ADC controller and the gate-driver pins.

---
 rtl/pwm_multi_dt.sv | 168 ++++++++++++++++
 tb/tb_pwm_multi_dt.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_dt.sv
// pwm_multi_dt: shared-carrier multi-channel PWM with complementary
// dead-time outputs, carrier-locked ADC trigger and double-buffered config.
module pwm_multi_dt #(
    parameter int CH   = 2,
    parameter int W    = 26,
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [W-1:0]    period,
    input  logic [CH*W-1:0] duty,
    input  logic [CH*W-1:0] phase,
    input  logic [DT_W-1:0] dead_time,
    input  logic [W-1:0]    trig_cmp,
    input  logic            load,
    output logic [W-1:0]    cnt,
    output logic            period_end,
    output logic            adc_trig,
    output logic            load_done,
    output logic [CH-1:0]   pwm_h,
    output logic [CH-1:0]   pwm_l
);

    logic [W-1:0]    per_p_q, per_p_d, per_s_q, per_s_d;
    logic [CH*W-1:0] duty_p_q, duty_p_d, duty_s_q, duty_s_d;
    logic [CH*W-1:0] ph_p_q, ph_p_d, ph_s_q, ph_s_d;
    logic [DT_W-1:0] dt_p_q, dt_p_d, dt_s_q, dt_s_d;
    logic [W-1:0]    trg_p_q, trg_p_d, trg_s_q, trg_s_d;
    logic            pend_q, pend_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic            trig_q, trig_d;
    logic            done_q, done_d;
    logic            act_q, act_d;
    logic [CH-1:0]   h_q, h_d, l_q, l_d, last_q, last_d;
    logic [CH-1:0][DT_W-1:0] k_q, k_d;

    logic            run, upd;
    logic [CH-1:0]   raw;
    logic [W-1:0]    ph_w;
    logic [W:0]      c_w;
    logic [DT_W-1:0] k_w;

    always_comb begin
        run = en && (per_s_q != '0);
        upd = pend_q && (!en || (cnt_q == per_s_q));

        per_p_d  = per_p_q;
        duty_p_d = duty_p_q;
        ph_p_d   = ph_p_q;
        dt_p_d   = dt_p_q;
        trg_p_d  = trg_p_q;
        pend_d   = pend_q && !upd;
        if (load) begin
            per_p_d  = period;
            duty_p_d = duty;
            ph_p_d   = phase;
            dt_p_d   = dead_time;
            trg_p_d  = trig_cmp;
            pend_d   = 1'b1;
        end

        per_s_d  = per_s_q;
        duty_s_d = duty_s_q;
        ph_s_d   = ph_s_q;
        dt_s_d   = dt_s_q;
        trg_s_d  = trg_s_q;
        if (upd) begin
            per_s_d  = per_p_q;
            duty_s_d = duty_p_q;
            ph_s_d   = ph_p_q;
            dt_s_d   = dt_p_q;
            trg_s_d  = trg_p_q;
        end

        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == per_s_q) ? '0 : cnt_q + W'(1);
        end
        trig_d = run && (cnt_q == trg_s_q);
        done_d = upd;
        act_d  = run;

        h_d    = '0;
        l_d    = '0;
        last_d = '0;
        k_d    = '0;
        raw    = '0;
        ph_w   = '0;
        c_w    = '0;
        k_w    = '0;
        for (int i = 0; i < CH; i++) begin
            ph_w = ph_s_q[i*W +: W];
            if (ph_w > per_s_q) begin
                ph_w = '0;
            end
            // W+1 bits so cnt+phase cannot overflow before folding
            c_w = {1'b0, cnt_q} + {1'b0, ph_w};
            if (c_w > {1'b0, per_s_q}) begin
                c_w = c_w - {1'b0, per_s_q} - (W+1)'(1);
            end
            raw[i] = run && (c_w < {1'b0, duty_s_q[i*W +: W]});
            // k_w: prior consecutive cycles at this level, saturating
            k_w = '0;
            if (act_q && (raw[i] == last_q[i])) begin
                k_w = (&k_q[i]) ? k_q[i] : k_q[i] + DT_W'(1);
            end
            if (run) begin
                h_d[i]    = raw[i] && (k_w >= dt_s_q);
                l_d[i]    = !raw[i] && (k_w >= dt_s_q);
                last_d[i] = raw[i];
                k_d[i]    = k_w;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_p_q  <= '0;
            duty_p_q <= '0;
            ph_p_q   <= '0;
            dt_p_q   <= '0;
            trg_p_q  <= '0;
            pend_q   <= 1'b0;
            per_s_q  <= '0;
            duty_s_q <= '0;
            ph_s_q   <= '0;
            dt_s_q   <= '0;
            trg_s_q  <= '0;
            cnt_q    <= '0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
            act_q    <= 1'b0;
            h_q      <= '0;
            l_q      <= '0;
            last_q   <= '0;
            k_q      <= '0;
        end else begin
            per_p_q  <= per_p_d;
            duty_p_q <= duty_p_d;
            ph_p_q   <= ph_p_d;
            dt_p_q   <= dt_p_d;
            trg_p_q  <= trg_p_d;
            pend_q   <= pend_d;
            per_s_q  <= per_s_d;
            duty_s_q <= duty_s_d;
            ph_s_q   <= ph_s_d;
            dt_s_q   <= dt_s_d;
            trg_s_q  <= trg_s_d;
            cnt_q    <= cnt_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
            act_q    <= act_d;
            h_q      <= h_d;
            l_q      <= l_d;
            last_q   <= last_d;
            k_q      <= k_d;
        end
    end

    assign cnt        = cnt_q;
    assign period_end = run && (cnt_q == per_s_q);
    assign adc_trig   = trig_q;
    assign load_done  = done_q;
    assign pwm_h      = h_q;
    assign pwm_l      = l_q;

endmodule

// File: tb/tb_pwm_multi_dt.sv
// Bench for pwm_multi_dt: cycle-level behavioural model with directed
// literal checks and randomized configuration/enable/reset traffic.
module tb_pwm_multi_dt;
    localparam int CH   = 2;
    localparam int W    = 26;
    localparam int DT_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic            load = 1'b0;
    logic [W-1:0]    period = '0;
    logic [W-1:0]    trig_cmp = '0;
    logic [CH*W-1:0] duty = '0;
    logic [CH*W-1:0] phase = '0;
    logic [DT_W-1:0] dead_time = '0;
    logic [W-1:0]    cnt;
    logic            period_end, adc_trig, load_done;
    logic [CH-1:0]   pwm_h, pwm_l;

    int errors = 0;
    int checks = 0;

    pwm_multi_dt #(.CH(CH), .W(W), .DT_W(DT_W)) dut (
        .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
        .phase(phase), .dead_time(dead_time), .trig_cmp(trig_cmp),
        .load(load), .cnt(cnt), .period_end(period_end),
        .adc_trig(adc_trig), .load_done(load_done),
        .pwm_h(pwm_h), .pwm_l(pwm_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model state
    int m_cnt;
    bit m_trig, m_done;
    bit m_h[CH];
    bit m_l[CH];
    int s_per, s_dt, s_trg;
    int s_duty[CH];
    int s_ph[CH];
    int p_per, p_dt, p_trg;
    int p_duty[CH];
    int p_ph[CH];
    bit p_flag;
    bit hrun[512];
    bit hraw[CH][512];
    int hn;

    task automatic model_reset();
        m_cnt = 0; m_trig = 0; m_done = 0; p_flag = 0; hn = 0;
        s_per = 0; s_dt = 0; s_trg = 0; p_per = 0; p_dt = 0; p_trg = 0;
        for (int c = 0; c < CH; c++) begin
            m_h[c] = 0; m_l[c] = 0;
            s_duty[c] = 0; s_ph[c] = 0; p_duty[c] = 0; p_ph[c] = 0;
        end
    endtask

    task automatic model_step();
        bit run_i, upd_i, ok;
        bit r[CH];
        bit nh[CH];
        bit nl[CH];
        int ph, c, idx;
        run_i = en && (s_per != 0);
        upd_i = p_flag && (!en || m_cnt == s_per);
        for (int k = 0; k < CH; k++) begin
            ph = (s_ph[k] > s_per) ? 0 : s_ph[k];
            c = (m_cnt + ph) % (s_per + 1);
            r[k] = run_i && (c < s_duty[k]);
            ok = 1;
            for (int j = 1; j <= s_dt; j++) begin
                if (j > hn) ok = 0;
                else begin
                    idx = (hn - j) % 512;
                    if (!hrun[idx] || hraw[k][idx] != r[k]) ok = 0;
                end
            end
            nh[k] = run_i && r[k] && ok;
            nl[k] = run_i && !r[k] && ok;
        end
        hrun[hn % 512] = run_i;
        for (int k = 0; k < CH; k++) hraw[k][hn % 512] = r[k];
        hn++;
        m_trig = run_i && (m_cnt == s_trg);
        m_done = upd_i;
        m_cnt = run_i ? ((m_cnt == s_per) ? 0 : m_cnt + 1) : 0;
        for (int k = 0; k < CH; k++) begin
            m_h[k] = nh[k]; m_l[k] = nl[k];
        end
        if (upd_i) begin
            s_per = p_per; s_dt = p_dt; s_trg = p_trg;
            for (int k = 0; k < CH; k++) begin
                s_duty[k] = p_duty[k]; s_ph[k] = p_ph[k];
            end
        end
        if (load) begin
            p_per = int'(period); p_dt = int'(dead_time); p_trg = int'(trig_cmp);
            for (int k = 0; k < CH; k++) begin
                p_duty[k] = int'(duty[k*W +: W]);
                p_ph[k] = int'(phase[k*W +: W]);
            end
            p_flag = 1;
        end else if (upd_i) p_flag = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cnt", int'(cnt), m_cnt);
            chk("period_end", int'(period_end),
                int'(en && s_per != 0 && m_cnt == s_per));
            chk("adc_trig", int'(adc_trig), int'(m_trig));
            chk("load_done", int'(load_done), int'(m_done));
            for (int k = 0; k < CH; k++) begin
                chk($sformatf("pwm_h[%0d]", k), int'(pwm_h[k]), int'(m_h[k]));
                chk($sformatf("pwm_l[%0d]", k), int'(pwm_l[k]), int'(m_l[k]));
            end
            chk("h_and_l", int'(|(pwm_h & pwm_l)), 0);
        end
    end

    // window accumulators
    int w_h0, w_l0, w_h1, w_l1, w_pe, w_trg, w_done;
    bit w_s0[32];
    bit w_s1[32];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic window(input int n);
        w_h0 = 0; w_l0 = 0; w_h1 = 0; w_l1 = 0; w_pe = 0; w_trg = 0; w_done = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_h0 += int'(pwm_h[0]); w_l0 += int'(pwm_l[0]);
            w_h1 += int'(pwm_h[1]); w_l1 += int'(pwm_l[1]);
            w_pe += int'(period_end); w_trg += int'(adc_trig);
            w_done += int'(load_done);
            if (i < 32) begin
                w_s0[i] = pwm_h[0]; w_s1[i] = pwm_h[1];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int per, input int d0, input int d1,
                           input int f0, input int f1, input int dt, input int tg);
        period = W'(per);
        duty[0 +: W] = W'(d0); duty[W +: W] = W'(d1);
        phase[0 +: W] = W'(f0); phase[W +: W] = W'(f1);
        dead_time = DT_W'(dt);
        trig_cmp = W'(tg);
    endtask

    task automatic do_load(input int per, input int d0, input int d1,
                           input int f0, input int f1, input int dt, input int tg);
        set_cfg(per, d0, d1, f0, f1, dt, tg);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic wait_mcnt(input int v, input string name);
        int g;
        g = 0;
        while (m_cnt != v && g < 50) begin
            step(1);
            g++;
        end
        chk(name, int'(g < 50), 1);
    endtask

    initial begin
        int r, mism, per;
        step(2);
        rst = 1'b0;

        // basic 50-ish percent, no dead time
        do_load(9, 4, 4, 0, 0, 0, 7);
        en = 1'b1;
        step(20);
        window(10);
        chk("dt0_h0_count", w_h0, 4);
        chk("dt0_l0_count", w_l0, 6);
        chk("dt0_pe_count", w_pe, 1);
        chk("trig7_count", w_trg, 1);

        // phase shift on channel 1
        do_load(9, 4, 4, 0, 5, 0, 7);
        step(25);
        window(20);
        mism = 0;
        for (int k = 0; k < 10; k++) if (w_s1[k] != w_s0[k+5]) mism++;
        chk("phase_shift_mism", mism, 0);
        chk("phase_h1_count", w_h1, 8);

        // duty above period -> constant high
        do_load(9, 4, 12, 0, 5, 0, 7);
        step(25);
        window(10);
        chk("full_h1_count", w_h1, 10);
        chk("full_l1_count", w_l1, 0);

        // dead time 2
        do_load(9, 4, 12, 0, 0, 2, 7);
        step(25);
        window(10);
        chk("dt2_h0_count", w_h0, 2);
        chk("dt2_l0_count", w_l0, 4);
        chk("dt2_h1_count", w_h1, 10);
        do_load(9, 1, 12, 0, 0, 2, 7);
        step(25);
        window(10);
        chk("dt2_short_h0", w_h0, 0);
        chk("dt2_short_l0", w_l0, 7);

        // trigger beyond period
        do_load(9, 4, 4, 0, 0, 0, 15);
        step(25);
        window(20);
        chk("trig15_count", w_trg, 0);

        // running load at cnt=3
        do_load(9, 4, 4, 0, 0, 0, 7);
        step(25);
        wait_mcnt(3, "wait_cnt3");
        do_load(9, 8, 4, 0, 0, 0, 7);
        window(12);
        chk("mid_load_done", w_done, 1);
        window(10);
        chk("new_duty_h0", w_h0, 8);

        // load coincident with wrap applies one period later
        wait_mcnt(9, "wait_cnt9");
        do_load(9, 2, 4, 0, 0, 0, 7);
        window(10);
        chk("wrap_load_early", w_done, 0);
        window(1);
        chk("wrap_load_late", w_done, 1);

        // disable mid-run
        en = 1'b0;
        step(1);
        window(3);
        chk("dis_outputs", w_h0 + w_l0 + w_h1 + w_l1 + w_pe, 0);
        en = 1'b1;
        step(15);

        // asynchronous reset mid-cycle
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_h", int'(pwm_h), 0);
        chk("arst_l", int'(pwm_l), 0);
        chk("arst_trig", int'(adc_trig), 0);
        chk("arst_done", int'(load_done), 0);
        chk("arst_pe", int'(period_end), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            load = 1'b0;
            rst = 1'b0;
            r = $urandom_range(0, 199);
            if (r < 14) begin
                per = $urandom_range(0, 12);
                set_cfg(per, $urandom_range(0, per + 3), $urandom_range(0, per + 3),
                        $urandom_range(0, per + 3), $urandom_range(0, per + 3),
                        $urandom_range(0, 4), $urandom_range(0, per + 3));
                load = 1'b1;
            end else if (r < 18) en = ~en;
            else if (r == 18) rst = 1'b1;
            step(1);
        end
        load = 1'b0;
        rst = 1'b0;
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
